// File: rtl/store_buffer_pkg.sv
// Shared data-memory access-type codes plus the size and load-extension helpers
// used by the store buffer, its range comparator and the memory model.
package store_buffer_pkg;

  localparam logic [2:0] DM_BYTE   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_WORD   = 3'b010;
  localparam logic [2:0] DM_BYTE_U = 3'b100;
  localparam logic [2:0] DM_HALF_U = 3'b101;

  // Unknown codes size as a word so an unrecognised access never under-reports overlap.
  function automatic logic [2:0] dm_size(input logic [2:0] t);
    case (t)
      DM_BYTE, DM_BYTE_U: dm_size = 3'd1;
      DM_HALF, DM_HALF_U: dm_size = 3'd2;
      default:            dm_size = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] dm_extend(input logic [31:0] d, input logic [2:0] t);
    case (t)
      DM_BYTE:   dm_extend = {{24{d[7]}}, d[7:0]};
      DM_BYTE_U: dm_extend = {24'd0, d[7:0]};
      DM_HALF:   dm_extend = {{16{d[15]}}, d[15:0]};
      DM_HALF_U: dm_extend = {16'd0, d[15:0]};
      default:   dm_extend = d;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Datapath-side store/load handshake and the data-memory port of the store buffer.
// master = datapath plus memory environment, slave = store buffer.
interface store_buffer_if #(parameter int AW = 9);
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [2:0]    st_type;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [2:0]    ld_type;
  logic [31:0]   ld_data;
  logic          ld_stall;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_din;
  logic [2:0]    dm_type;
  logic [31:0]   dm_dout;
  logic          sb_empty;

  modport master (
    output st_valid, st_addr, st_data, st_type, ld_req, ld_addr, ld_type, dm_dout,
    input  st_ready, ld_data, ld_stall, dm_wr, dm_addr, dm_din, dm_type, sb_empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_type, ld_req, ld_addr, ld_type, dm_dout,
    output st_ready, ld_data, ld_stall, dm_wr, dm_addr, dm_din, dm_type, sb_empty
  );
endinterface

// File: rtl/sb_range_cmp.sv
// Byte-range comparator between one pending store entry and the current load.
// Ranges are widened by one bit so an access at the top of memory never wraps.
module sb_range_cmp
  import store_buffer_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic [AW-1:0] i_e_addr,
  input  logic [2:0]    i_e_type,
  input  logic [AW-1:0] i_l_addr,
  input  logic [2:0]    i_l_type,
  output logic          o_overlap,
  output logic          o_exact_match
);

  logic [AW:0] w_e_lo, w_e_hi, w_l_lo, w_l_hi;

  assign w_e_lo = {1'b0, i_e_addr};
  assign w_l_lo = {1'b0, i_l_addr};
  assign w_e_hi = w_e_lo + (AW+1)'(dm_size(i_e_type)) - (AW+1)'(1);
  assign w_l_hi = w_l_lo + (AW+1)'(dm_size(i_l_type)) - (AW+1)'(1);

  assign o_overlap     = (w_e_lo <= w_l_hi) && (w_l_lo <= w_e_hi);
  assign o_exact_match = (i_e_addr == i_l_addr) && (dm_size(i_e_type) == dm_size(i_l_type));

endmodule

// File: rtl/store_buffer.sv
// Store buffer: FIFO of committed stores draining one per cycle into data memory,
// loads take the port first and stall on overlap. Define SB_FWD_EN for store-to-load forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 9
) (
  input logic          clk,
  input logic          rst,
  store_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [2:0]    r_type [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0]   r_count;

  logic [DEPTH-1:0] w_overlap, w_exact;
  logic             w_hit;
  logic [PW-1:0]    w_hit_idx;
  logic             w_fwd, w_stall, w_load_port, w_push, w_drain;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    sb_range_cmp #(.AW(AW)) u_cmp (
      .i_e_addr      (r_addr[g]),
      .i_e_type      (r_type[g]),
      .i_l_addr      (bus.ld_addr),
      .i_l_type      (bus.ld_type),
      .o_overlap     (w_overlap[g]),
      .o_exact_match (w_exact[g])
    );
  end

  // Scan oldest to youngest so the last valid overlap written is the youngest one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (((PW+1)'(k) < r_count) && w_overlap[r_tail - PW'(k + 1)]) begin
        w_hit     = 1'b1;
        w_hit_idx = r_tail - PW'(k + 1);
      end
    end
  end

`ifdef SB_FWD_EN
  assign w_fwd       = w_hit && w_exact[w_hit_idx];
  assign bus.ld_data = w_fwd ? dm_extend(r_data[w_hit_idx], bus.ld_type) : bus.dm_dout;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{w_exact, w_hit_idx};
  assign w_fwd        = 1'b0;
  assign bus.ld_data  = bus.dm_dout;
`endif

  assign w_stall      = bus.ld_req && w_hit && !w_fwd;
  assign w_load_port  = bus.ld_req && !w_stall && !w_fwd;
  assign w_drain      = (r_count != '0) && !w_load_port;
  assign w_push       = bus.st_valid && bus.st_ready;

  assign bus.st_ready = r_count < (PW+1)'(DEPTH);
  assign bus.sb_empty = r_count == '0;
  assign bus.ld_stall = w_stall;

  always_comb begin
    bus.dm_wr   = 1'b0;
    bus.dm_addr = '0;
    bus.dm_din  = '0;
    bus.dm_type = bus.ld_type;
    if (w_load_port) begin
      bus.dm_addr = bus.ld_addr;
    end else if (w_drain) begin
      bus.dm_wr   = 1'b1;
      bus.dm_addr = r_addr[r_head];
      bus.dm_din  = r_data[r_head];
      bus.dm_type = r_type[r_head];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)  r_tail <= r_tail + PW'(1);
      if (w_drain) r_head <= r_head + PW'(1);
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_drain);
    end
  end

  // NOTE: entry storage has no reset; r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.st_addr;
      r_data[r_tail] <= bus.st_data;
      r_type[r_tail] <= bus.st_type;
    end
  end

endmodule
